fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch front end for the RV32I pipeline. It replaces the single-cycle PC/IF logic with the following:
- a PC generator;
- a ready/valid request port to a variable-latency instruction memory;
- an in-order prefetch queue of configurable depth;
- redirect handling that flushes queued instructions and squashes in-flight responses.

The block feeds the IF/ID boundary through a valid/ready handshake. Decode stalls become back-pressure and no longer freeze the PC.

## Interface
- XLEN, 32: address/PC width.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- QUEUE_DEPTH, 4: prefetch entries; power of two, ≥2. It also caps outstanding requests.
- NOP_INSTR, 32'h0000_0013: value driven on id_instr when the queue is empty.

Ports:
- clk  in  1  clock. Everything is sampled on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid. Responses return in request order, with no back-pressure.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  branch/jump resolved taken (pc_sel ≠ 0 in EX).
- redirect_pc  in  XLEN  target; bits [1:0] are ignored (treated as 0).
- id_valid  out  1  head entry is valid.
- id_ready  in  1  decode accepts the head entry.
- id_pc  out  XLEN  PC of the head entry.
- id_pc_plus_4  out  XLEN  id_pc + 4, modulo 2^XLEN.
- id_instr  out  32  instruction at the head entry, or NOP_INSTR when empty.

## Operation
- State:
  - fetch_pc register.
  - Prefetch FIFO entries, each {pc, instr}.
  - out_cnt: accepted requests with no response yet, width $clog2(QUEUE_DEPTH+1).
  - drop_cnt: responses still to be discarded, same width.
- Credit rule: imem_req_valid = !reset && (fifo_count + out_cnt < QUEUE_DEPTH). This is a function of registers only. It never depends on redirect_valid or on id_ready.
- On a request handshake (valid && ready), fetch_pc advances by 4 (wraps at 2^XLEN) and out_cnt is incremented.
- A response pushes {pc, instr} when drop_cnt == 0. The pc field comes from a per-request PC tracked in order: a small PC FIFO of depth QUEUE_DEPTH, or response-PC = running counter. If drop_cnt > 0, the response is discarded and drop_cnt is decremented. Every response decrements out_cnt.
- A pop happens when id_valid && id_ready.
- Redirect handling, all in the same edge:
  - fetch_pc ← redirect_pc.
  - The FIFO is cleared, including a push or pop occurring that cycle.
  - drop_cnt ← out_cnt_next, i.e. the count after this cycle's request and response are applied. Any request handshaked in the redirect cycle is therefore squashed.
  - The response PC tracker restarts at redirect_pc.
- Redirect while drop_cnt > 0: drop_cnt is recomputed the same way, so there is no accumulation error.
- Simultaneous push and pop on a full FIFO is legal. Count is unchanged.
- Invariant: fifo_count + out_cnt ≤ QUEUE_DEPTH at all times. Under this invariant the FIFO cannot overflow, since memory cannot stall responses.
- Reset (synchronous): fetch_pc=RESET_PC, FIFO empty, out_cnt=0, drop_cnt=0. Reset taken mid-operation abandons in-flight requests; the memory is reset alongside this block. Reset dominates redirect.

## Timing
- Reset output values: imem_req_valid=0, imem_req_addr=RESET_PC, id_valid=0, id_pc=0, id_pc_plus_4=4, id_instr=NOP_INSTR.
- The first request is presented in the first cycle after reset deasserts.
- Latency is response-to-decode: the instruction is visible on the id_* outputs in the cycle after imem_rsp_valid. There is no FIFO bypass.
- With zero-wait memory (ready=1, response the next cycle) and id_ready=1, throughput is 1 instruction/cycle.
- The first post-redirect request is issued the cycle after redirect, subject to credit. id_valid is 0 in the cycle after redirect.
- id_* outputs are combinational from the FIFO head register.

## Structure
- Shared package `rv_pkg`: XLEN default, NOP_INSTR, and the fetch-entry struct {pc, instr}.
- One sub-module is natural: `sync_fifo` (parametrised WIDTH/DEPTH, with clear, count, full/empty). It is used for the instruction queue. An optional second instance holds request PCs.
- Target size: 150–300 lines of RTL.

## Test plan
- Zero-wait memory, id_ready=1, 8 sequential words from 0x0 → id_pc sequence 0x0,0x4,…,0x1C back-to-back, with 1 instruction/cycle after a 2-cycle fill.
- id_ready=0 for 10 cycles, then release → exactly QUEUE_DEPTH requests issued, then imem_req_valid=0. Draining delivers all instructions in order, none lost or duplicated.
- Memory latency 3 cycles with 3 requests outstanding, redirect_valid with redirect_pc=0x100 → the 3 late responses are dropped. Next id_pc=0x100 with the instruction at 0x100.
- redirect_valid in the same cycle as imem_rsp_valid and a request handshake → that response is dropped and that request's response is dropped. The queue is empty the next cycle.
- Reset asserted mid-stream with the FIFO full → the next cycle shows id_valid=0, id_instr=0x00000013, imem_req_addr=RESET_PC. The stream restarts at RESET_PC.
- fetch_pc=0xFFFF_FFFC sequential fetch → next address wraps to 0x0000_0000, and id_pc_plus_4 of that entry = 0x0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I front-end definitions: default widths, the canonical NOP,
// and the fetch-entry record handed from IF to ID.
package rv_pkg;
    localparam int          RV_XLEN   = 32;
    localparam int          RV_INSTR_W = 32;
    localparam logic [31:0] RV_NOP    = 32'h0000_0013;  // addi x0, x0, 0

    typedef struct packed {
        logic [RV_XLEN-1:0]    pc;
        logic [RV_INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear. The read port is the head
// register itself, so rdata is valid whenever empty is low.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;

    // Pointer/count update; clear discards any push or pop of the same cycle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generator, credit-limited request port to a
// variable-latency memory, in-order prefetch queue, and redirect flushing.
module fetch_unit
    import rv_pkg::*;
#(
    parameter int              XLEN        = RV_XLEN,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              QUEUE_DEPTH = 4,
    parameter logic [31:0]     NOP_INSTR   = RV_NOP
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus_4,
    output logic [31:0]     id_instr
);
    localparam int CW = $clog2(QUEUE_DEPTH+1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;       // PC of the next response that will be kept
    logic [XLEN-1:0] redirect_tgt;
    logic [CW-1:0]   out_cnt, out_cnt_next, drop_cnt, fifo_count;
    logic [CW:0]     credit_used;
    logic            req_fire, rsp_keep, fifo_pop, fifo_full, fifo_empty;
    entry_t          push_entry, head_entry;

    assign redirect_tgt = redirect_pc & ~XLEN'(3);

    // Queue slots plus in-flight requests never exceed the queue depth, so a
    // response can always be accepted even though memory cannot be stalled.
    assign credit_used    = {1'b0, fifo_count} + {1'b0, out_cnt};
    assign imem_req_valid = !reset && (credit_used < (CW+1)'(QUEUE_DEPTH));
    assign imem_req_addr  = fetch_pc;

    assign req_fire     = imem_req_valid && imem_req_ready;
    assign rsp_keep     = imem_rsp_valid && (drop_cnt == '0);
    assign fifo_pop     = id_valid && id_ready;
    assign out_cnt_next = out_cnt + CW'(req_fire) - CW'(imem_rsp_valid);
    assign push_entry   = '{pc: rsp_pc, instr: imem_rsp_data};

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .clear (redirect_valid),
        .push  (rsp_keep),
        .pop   (fifo_pop),
        .wdata (push_entry),
        .rdata (head_entry),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // PC generation, response-PC tracking and in-flight/squash bookkeeping.
    // On redirect every request still in flight after this edge, including
    // one accepted this very cycle, is marked for discard.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            out_cnt <= out_cnt_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_tgt;
                rsp_pc   <= redirect_tgt;
                drop_cnt <= out_cnt_next;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + XLEN'(4);
                if (rsp_keep)
                    rsp_pc <= rsp_pc + XLEN'(4);
                else if (imem_rsp_valid)
                    drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    // The credit scheme makes a push into a full queue without a pop impossible.
    assert property (@(posedge clk) disable iff (reset)
        !(rsp_keep && fifo_full && !fifo_pop));

    assign id_valid     = !fifo_empty;
    assign id_pc        = fifo_empty ? '0 : head_entry.pc;
    assign id_instr     = fifo_empty ? NOP_INSTR : head_entry.instr;
    assign id_pc_plus_4 = id_pc + XLEN'(4);
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order variable-latency memory model plus a
// sequential-stream reference (next PC = previous + 4, or the redirect target).
module tb_fetch_unit;
    localparam int          QD  = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_pc_plus_4, id_instr;

    fetch_unit #(.XLEN(32), .RESET_PC(RPC), .QUEUE_DEPTH(QD), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_pc_plus_4   (id_pc_plus_4),
        .id_instr       (id_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t pend[$];
    int    cyc, last_due, ready_pct, lat_min, lat_max;
    int    total = 0;
    int    bad   = 0;

    logic        obs_req, obs_idv, obs_pop;
    logic [31:0] obs_req_addr, obs_pc, obs_instr, obs_p4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[17:2], ~a[17:2]} ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: drive memory, sample DUT mid-cycle, advance to next negedge.
    task automatic step();
        int due;
        if (reset) begin
            pend.delete();
            last_due = -1;
        end
        if (!reset && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = ($urandom_range(0, 99) < ready_pct);
        #1;
        obs_req      = imem_req_valid && imem_req_ready;
        obs_req_addr = imem_req_addr;
        if (obs_req) begin
            due = cyc + $urandom_range(lat_min, lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{addr: imem_req_addr, due: due});
        end
        obs_idv   = id_valid;
        obs_pop   = id_valid && id_ready;
        obs_pc    = id_pc;
        obs_instr = id_instr;
        obs_p4    = id_pc_plus_4;
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        ready_pct = 100; lat_min = 1; lat_max = 1;
        step(); step();
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        ready_pct = 100; lat_min = 1; lat_max = 1;
        step(); step();
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b want=0", imem_req_valid); end
        total++; if (imem_req_addr !== RPC) begin bad++; $display("FAIL rst_req_addr got=%h want=%h", imem_req_addr, RPC); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rst_id_valid got=%b want=0", id_valid); end
        total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL rst_id_pc got=%h want=0", id_pc); end
        total++; if (id_pc_plus_4 !== 32'h4) begin bad++; $display("FAIL rst_id_pc_plus_4 got=%h want=4", id_pc_plus_4); end
        total++; if (id_instr !== NOP) begin bad++; $display("FAIL rst_id_instr got=%h want=%h", id_instr, NOP); end
        reset = 1'b0; cyc = 0;
        step();
        total++; if (!(obs_req === 1'b1 && obs_req_addr === RPC)) begin
            bad++; $display("FAIL first_req got=%b/%h want=1/%h", obs_req, obs_req_addr, RPC);
        end
    endtask

    task automatic test_sequential();
        int n = 0;
        do_reset();
        id_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            step();
            if (obs_pop && n < 8) begin
                total++; if (obs_pc !== 32'(n*4)) begin bad++; $display("FAIL seq_pc got=%h want=%h", obs_pc, 32'(n*4)); end
                total++; if (obs_instr !== mem_word(32'(n*4))) begin bad++; $display("FAIL seq_instr got=%h want=%h", obs_instr, mem_word(32'(n*4))); end
                total++; if (c != n + 2) begin bad++; $display("FAIL seq_timing got=cycle%0d want=cycle%0d", c, n + 2); end
                n++;
            end
        end
        total++; if (n != 8) begin bad++; $display("FAIL seq_count got=%0d want=8", n); end
    endtask

    task automatic test_backpressure();
        int reqs = 0;
        int n = 0;
        do_reset();
        id_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (obs_req) reqs++;
        end
        total++; if (reqs != QD) begin bad++; $display("FAIL bp_req_count got=%0d want=%0d", reqs, QD); end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_req_valid got=%b want=0", imem_req_valid); end
        id_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (obs_pop) begin
                total++; if (obs_pc !== 32'(n*4) || obs_instr !== mem_word(32'(n*4))) begin
                    bad++; $display("FAIL bp_drain got=%h/%h want=%h/%h", obs_pc, obs_instr, 32'(n*4), mem_word(32'(n*4)));
                end
                n++;
            end
        end
        total++; if (n < 15) begin bad++; $display("FAIL bp_drain_count got=%0d want>=15", n); end
    endtask

    task automatic test_redirect_latency();
        int n = 0;
        int first_cyc = -1;
        do_reset();
        id_ready = 1'b1; lat_min = 3; lat_max = 3;
        step(); step();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        step();
        total++; if (obs_idv !== 1'b0) begin bad++; $display("FAIL rl_idv_after got=%b want=0", obs_idv); end
        total++; if (!(obs_req === 1'b1 && obs_req_addr === 32'h100)) begin
            bad++; $display("FAIL rl_first_req got=%b/%h want=1/00000100", obs_req, obs_req_addr);
        end
        for (int c = 0; c < 10; c++) begin
            step();
            if (obs_pop) begin
                if (first_cyc < 0) first_cyc = cyc - 1;
                total++; if (obs_pc !== 32'h100 + 32'(n*4) || obs_instr !== mem_word(32'h100 + 32'(n*4))) begin
                    bad++; $display("FAIL rl_stream got=%h/%h want=%h/%h", obs_pc, obs_instr, 32'h100 + 32'(n*4), mem_word(32'h100 + 32'(n*4)));
                end
                n++;
            end
        end
        total++; if (first_cyc != 7) begin bad++; $display("FAIL rl_first_pop got=cycle%0d want=cycle7", first_cyc); end
    endtask

    task automatic test_redirect_collide();
        int n = 0;
        int first_cyc = -1;
        do_reset();
        id_ready = 1'b1;
        for (int c = 0; c < 5; c++) step();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        total++; if (!(obs_req === 1'b1 && imem_rsp_valid === 1'b1)) begin
            bad++; $display("FAIL col_setup got=req%b/rsp%b want=1/1", obs_req, imem_rsp_valid);
        end
        step();
        total++; if (obs_idv !== 1'b0) begin bad++; $display("FAIL col_empty got=%b want=0", obs_idv); end
        step();
        total++; if (obs_idv !== 1'b0) begin bad++; $display("FAIL col_dropped got=%b want=0", obs_idv); end
        for (int c = 0; c < 6; c++) begin
            step();
            if (obs_pop) begin
                if (first_cyc < 0) first_cyc = cyc - 1;
                total++; if (obs_pc !== 32'h200 + 32'(n*4)) begin bad++; $display("FAIL col_stream got=%h want=%h", obs_pc, 32'h200 + 32'(n*4)); end
                n++;
            end
        end
        total++; if (first_cyc != 8) begin bad++; $display("FAIL col_first_pop got=cycle%0d want=cycle8", first_cyc); end
    endtask

    task automatic test_reset_midstream();
        int n = 0;
        do_reset();
        id_ready = 1'b0;
        for (int c = 0; c < 8; c++) step();
        total++; if (!(obs_idv === 1'b1 && imem_req_valid === 1'b0)) begin
            bad++; $display("FAIL mid_full got=idv%b/req%b want=1/0", obs_idv, imem_req_valid);
        end
        reset = 1'b1;
        step();
        reset = 1'b0; cyc = 0;
        step();
        total++; if (obs_idv !== 1'b0) begin bad++; $display("FAIL mid_idv got=%b want=0", obs_idv); end
        total++; if (obs_instr !== NOP) begin bad++; $display("FAIL mid_instr got=%h want=%h", obs_instr, NOP); end
        total++; if (obs_req_addr !== RPC) begin bad++; $display("FAIL mid_addr got=%h want=%h", obs_req_addr, RPC); end
        id_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            if (obs_pop) begin
                total++; if (obs_pc !== RPC + 32'(n*4)) begin bad++; $display("FAIL mid_restart got=%h want=%h", obs_pc, RPC + 32'(n*4)); end
                n++;
            end
        end
        total++; if (n < 5) begin bad++; $display("FAIL mid_restart_count got=%0d want>=5", n); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_f = 32'hFFFF_FFF8;
        logic [31:0] exp_i = 32'hFFFF_FFF8;
        int n = 0;
        do_reset();
        id_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (obs_req) begin
                total++; if (obs_req_addr !== exp_f) begin bad++; $display("FAIL wrap_req got=%h want=%h", obs_req_addr, exp_f); end
                exp_f = exp_f + 32'd4;
            end
            if (obs_pop) begin
                total++; if (obs_pc !== exp_i || obs_p4 !== exp_i + 32'd4 || obs_instr !== mem_word(exp_i)) begin
                    bad++; $display("FAIL wrap_pop got=%h/%h/%h want=%h/%h/%h", obs_pc, obs_p4, obs_instr, exp_i, exp_i + 32'd4, mem_word(exp_i));
                end
                exp_i = exp_i + 32'd4;
                n++;
            end
        end
        total++; if (n < 3) begin bad++; $display("FAIL wrap_count got=%0d want>=3", n); end
    endtask

    task automatic test_random();
        logic [31:0] exp_fetch, exp_id, tgt;
        logic        redir, prev_redir;
        int          pops = 0;
        do_reset();
        exp_fetch = RPC; exp_id = RPC; prev_redir = 1'b0;
        lat_min = 1; lat_max = 4;
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) ready_pct = $urandom_range(30, 100);
            id_ready       = ($urandom_range(0, 99) < 70);
            redir          = ($urandom_range(0, 99) < 3);
            tgt            = $urandom;
            redirect_valid = redir;
            redirect_pc    = tgt;
            step();
            if (obs_req) begin
                total++; if (obs_req_addr !== exp_fetch) begin bad++; $display("FAIL rnd_req got=%h want=%h", obs_req_addr, exp_fetch); end
                exp_fetch = exp_fetch + 32'd4;
            end
            if (prev_redir) begin
                total++; if (obs_idv !== 1'b0) begin bad++; $display("FAIL rnd_idv_after_redirect got=%b want=0", obs_idv); end
            end
            if (!obs_idv) begin
                total++; if (obs_pc !== 32'h0 || obs_instr !== NOP) begin bad++; $display("FAIL rnd_idle got=%h/%h want=0/%h", obs_pc, obs_instr, NOP); end
            end
            if (obs_pop && !redir) begin
                total++; if (obs_pc !== exp_id || obs_instr !== mem_word(exp_id) || obs_p4 !== exp_id + 32'd4) begin
                    bad++; $display("FAIL rnd_pop got=%h/%h/%h want=%h/%h/%h", obs_pc, obs_instr, obs_p4, exp_id, mem_word(exp_id), exp_id + 32'd4);
                end
                exp_id = exp_id + 32'd4;
                pops++;
            end
            if (redir) begin
                exp_fetch = tgt & ~32'h3;
                exp_id    = exp_fetch;
            end
            total++; if (pend.size() > QD) begin bad++; $display("FAIL rnd_outstanding got=%0d want<=%0d", pend.size(), QD); end
            prev_redir = redir;
        end
        redirect_valid = 1'b0;
        total++; if (pops < 100) begin bad++; $display("FAIL rnd_progress got=%0d want>=100", pops); end
    endtask

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        cyc = 0; last_due = -1; ready_pct = 100; lat_min = 1; lat_max = 1;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_latency();
        test_redirect_collide();
        test_reset_midstream();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
